// File: rtl/psum_pkg.sv
// Shared types and defaults for the partial-sum collector and its output stages.
package psum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } psum_state_t;

    localparam int PSUM_W_DEF    = 10;
    localparam int OUT_W_DEF     = 12;
    localparam int ROWS_DEF      = 3;
    localparam int OFMAP_LEN_DEF = 3;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_collector_if.sv
// Partial-sum input stream and ofmap output stream of the collector.
interface psum_collector_if #(
    parameter int PSUM_W = 10,
    parameter int OUT_W  = 12
);
    logic              psum_valid;
    logic              psum_ready;
    logic [PSUM_W-1:0] psum_data;
    logic              ofmap_valid;
    logic              ofmap_ready;
    logic [OUT_W-1:0]  ofmap_data;
    logic              ofmap_last;

    modport slave (
        input  psum_valid, psum_data, ofmap_ready,
        output psum_ready, ofmap_valid, ofmap_data, ofmap_last
    );

    modport master (
        output psum_valid, psum_data, ofmap_ready,
        input  psum_ready, ofmap_valid, ofmap_data, ofmap_last
    );
endinterface

// File: rtl/psum_sat.sv
// Combinational unsigned saturating width converter: clips to all-ones when narrowing.
module psum_sat #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 12
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o
);

    generate
        if (OUT_W >= IN_W) begin : g_widen
            assign out_o = OUT_W'(in_i);
        end else begin : g_clip
            assign out_o = (|in_i[IN_W-1:OUT_W]) ? {OUT_W{1'b1}} : in_i[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/psum_collector.sv
// Sums ROWS passes of row partial sums element-wise, then drains the saturated ofmap.
module psum_collector
    import psum_pkg::*;
#(
    parameter int PSUM_W    = PSUM_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int OFMAP_LEN = OFMAP_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    psum_collector_if.slave   bus,
    output logic              frame_done
);

    localparam int ACC_W = PSUM_W + $clog2(ROWS);
    localparam int IDX_W = cnt_w(OFMAP_LEN);
    localparam int ROW_W = cnt_w(ROWS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OFMAP_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    psum_state_t      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             psum_ready_q, psum_ready_d;
    logic             frame_done_q, frame_done_d;
    logic [ACC_W-1:0] acc_q [OFMAP_LEN];
    logic             acc_we_s;
    logic [ACC_W-1:0] acc_wdata_s;
    logic [OUT_W-1:0] sat_s;
    logic             psum_hs_s;
    logic             ofmap_hs_s;

    assign psum_hs_s   = bus.psum_valid & psum_ready_q;
    assign ofmap_hs_s  = bus.ofmap_valid & bus.ofmap_ready;
    // The first row pass overwrites, so stale buffer contents never leak into a frame.
    assign acc_wdata_s = (row_q == '0) ? ACC_W'(bus.psum_data)
                                       : acc_q[idx_q] + ACC_W'(bus.psum_data);

    psum_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_sat (
        .in_i  (acc_q[idx_q]),
        .out_o (sat_s)
    );

    assign bus.psum_ready  = psum_ready_q;
    assign bus.ofmap_valid = (state_q == DRAIN);
    assign bus.ofmap_data  = (state_q == DRAIN) ? sat_s : '0;
    assign bus.ofmap_last  = (state_q == DRAIN) && (idx_q == IDX_LAST);
    assign frame_done      = frame_done_q;

    // Next-state, counter and buffer-write decode; clr overrides any handshake.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        row_d        = row_q;
        psum_ready_d = psum_ready_q;
        frame_done_d = 1'b0;
        acc_we_s     = 1'b0;
        if (clr) begin
            state_d      = ACCUM;
            idx_d        = '0;
            row_d        = '0;
            psum_ready_d = 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    psum_ready_d = 1'b1;
                    if (psum_hs_s) begin
                        acc_we_s = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d = '0;
                            if (row_q == ROW_LAST) begin
                                row_d        = '0;
                                state_d      = DRAIN;
                                psum_ready_d = 1'b0;
                            end else begin
                                row_d = row_q + ROW_W'(1);
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        acc_we_s = 1'b0;
                    end
                end
                DRAIN: begin
                    psum_ready_d = 1'b0;
                    if (ofmap_hs_s) begin
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            row_d        = '0;
                            state_d      = ACCUM;
                            psum_ready_d = 1'b1;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: begin
                    state_d      = ACCUM;
                    idx_d        = '0;
                    row_d        = '0;
                    psum_ready_d = 1'b0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACCUM;
            idx_q        <= '0;
            row_q        <= '0;
            psum_ready_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            row_q        <= row_d;
            psum_ready_q <= psum_ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Accumulation buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OFMAP_LEN; i++) begin
                acc_q[i] <= '0;
            end
        end else if (acc_we_s && !clr) begin
            acc_q[idx_q] <= acc_wdata_s;
        end else begin
            acc_q <= acc_q;
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench: a default build and an OUT_W=10 build share one stimulus stream.
module tb_psum_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       psum_valid = 1'b0;
    logic [9:0] psum_data = 10'd0;
    logic       ofmap_ready = 1'b0;
    logic       fd_a;
    logic       fd_b;
    int         vec = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    psum_collector_if #(.PSUM_W(10), .OUT_W(12)) ifa ();
    psum_collector_if #(.PSUM_W(10), .OUT_W(10)) ifb ();

    assign ifa.psum_valid  = psum_valid;
    assign ifa.psum_data   = psum_data;
    assign ifa.ofmap_ready = ofmap_ready;
    assign ifb.psum_valid  = psum_valid;
    assign ifb.psum_data   = psum_data;
    assign ifb.ofmap_ready = ofmap_ready;

    psum_collector #(.PSUM_W(10), .OUT_W(12), .ROWS(3), .OFMAP_LEN(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa.slave), .frame_done(fd_a)
    );

    psum_collector #(.PSUM_W(10), .OUT_W(10), .ROWS(3), .OFMAP_LEN(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifb.slave), .frame_done(fd_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " ready_a"}, 32'(ifa.psum_ready), 32'd0);
        chk({tag, " valid_a"}, 32'(ifa.ofmap_valid), 32'd0);
        chk({tag, " data_a"}, 32'(ifa.ofmap_data), 32'd0);
        chk({tag, " last_a"}, 32'(ifa.ofmap_last), 32'd0);
        chk({tag, " done_a"}, 32'(fd_a), 32'd0);
        chk({tag, " valid_b"}, 32'(ifb.ofmap_valid), 32'd0);
        chk({tag, " data_b"}, 32'(ifb.ofmap_data), 32'd0);
    endtask

    task automatic send(input logic [9:0] d, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            psum_valid = 1'b0;
        end
        @(negedge clk);
        psum_valid = 1'b1;
        psum_data  = d;
        n = 0;
        while (!ifa.psum_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("psum_ready timeout", 32'(ifa.psum_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input logic [9:0] p0, input logic [9:0] p1, input logic [9:0] p2,
                              input int gap);
        send(p0, gap); send(p1, 0);   send(p2, gap);
        send(10'(p0 * 10), 0); send(10'(p1 * 10), gap); send(10'(p2 * 10), 0);
        send(10'(p0 * 100), gap); send(10'(p1 * 100), 0); send(10'(p2 * 100), gap);
    endtask

    task automatic recv(input logic [31:0] exp_a, input logic [31:0] exp_b, input logic exp_last);
        int n;
        @(negedge clk);
        n = 0;
        while (!ifa.ofmap_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ofmap_valid_a", 32'(ifa.ofmap_valid), 32'd1);
        chk("ofmap_valid_b", 32'(ifb.ofmap_valid), 32'd1);
        chk("psum_ready in drain", 32'(ifa.psum_ready), 32'd0);
        chk("ofmap_data_a", 32'(ifa.ofmap_data), exp_a);
        chk("ofmap_data_b", 32'(ifb.ofmap_data), exp_b);
        chk("ofmap_last_a", 32'(ifa.ofmap_last), 32'(exp_last));
        ofmap_ready = 1'b1;
        @(posedge clk);
    endtask

    task automatic drain_start();
        @(negedge clk);
        psum_valid = 1'b0;
        chk("first beat latency", 32'(ifa.ofmap_valid), 32'd1);
        chk("ready low after final psum", 32'(ifa.psum_ready), 32'd0);
    endtask

    task automatic frame_end();
        @(negedge clk);
        ofmap_ready = 1'b0;
        chk("frame_done_a pulse", 32'(fd_a), 32'd1);
        chk("frame_done_b pulse", 32'(fd_b), 32'd1);
        chk("ready with frame_done", 32'(ifa.psum_ready), 32'd1);
        chk("valid after drain", 32'(ifa.ofmap_valid), 32'd0);
        @(negedge clk);
        chk("frame_done one cycle", 32'(fd_a), 32'd0);
    endtask

    initial begin
        // Reset: three cycles held low, all outputs zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle_outputs("reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after reset", 32'(ifa.psum_ready), 32'd1);

        // Nominal frame.
        send_frame(10'd1, 10'd2, 10'd3, 0);
        drain_start();
        recv(32'd111, 32'd111, 1'b0);
        recv(32'd222, 32'd222, 1'b0);
        recv(32'd333, 32'd333, 1'b1);
        frame_end();

        // Input gaps plus 5 cycles of backpressure on the first beat.
        send_frame(10'd1, 10'd2, 10'd3, 2);
        drain_start();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold valid", 32'(ifa.ofmap_valid), 32'd1);
            chk("hold data", 32'(ifa.ofmap_data), 32'd111);
            chk("hold last", 32'(ifa.ofmap_last), 32'd0);
        end
        recv(32'd111, 32'd111, 1'b0);
        recv(32'd222, 32'd222, 1'b0);
        recv(32'd333, 32'd333, 1'b1);
        frame_end();

        // Saturation: 3*1023 clips to 1023 on the 10-bit build only.
        for (int r = 0; r < 3; r++) begin
            send(10'd1023, 0); send(10'd5, 0); send(10'd5, 0);
        end
        drain_start();
        recv(32'd3069, 32'd1023, 1'b0);
        recv(32'd15, 32'd15, 1'b0);
        recv(32'd15, 32'd15, 1'b1);
        frame_end();

        // Abort after 4 psums; the beat in the clr cycle is discarded.
        send(10'd1, 0); send(10'd2, 0); send(10'd3, 0); send(10'd10, 0);
        @(negedge clk);
        clr = 1'b1;
        psum_valid = 1'b1;
        psum_data = 10'd999;
        @(negedge clk);
        clr = 1'b0;
        psum_valid = 1'b0;
        chk("ready after clr", 32'(ifa.psum_ready), 32'd1);
        chk("valid after clr", 32'(ifa.ofmap_valid), 32'd0);
        send_frame(10'd1, 10'd2, 10'd3, 0);
        drain_start();
        recv(32'd111, 32'd111, 1'b0);
        recv(32'd222, 32'd222, 1'b0);
        recv(32'd333, 32'd333, 1'b1);
        frame_end();

        // Reset in the middle of a drain.
        send_frame(10'd1, 10'd2, 10'd3, 0);
        drain_start();
        recv(32'd111, 32'd111, 1'b0);
        @(negedge clk);
        ofmap_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid-drain reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready after second reset", 32'(ifa.psum_ready), 32'd1);
        send_frame(10'd1, 10'd2, 10'd3, 1);
        drain_start();
        recv(32'd111, 32'd111, 1'b0);
        recv(32'd222, 32'd222, 1'b0);
        recv(32'd333, 32'd333, 1'b1);
        frame_end();

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
